// File: rtl/lfsr_8bit.sv
// -----------------------------------------------------------------------------
// lfsr_8bit
//
// Free-running maximal-length Fibonacci LFSR used as the pseudo-random source
// for the game/pattern logic. A synchronous reset loads a caller-supplied seed;
// every other rising clock edge shifts the register left by one and inserts
// the XOR of the tapped state bits at bit 0.
//
// Parameters
//   WIDTH  register width, legal 3..16 (anything else stops elaboration)
//   TAPS   tap-mask override; bit i set means state bit i feeds the XOR.
//          0 selects the built-in primitive-polynomial entry for WIDTH.
//
// Ports
//   clk         in   1      single clock, rising edge
//   reset       in   1      synchronous, active-high; loads seed
//   seed        in   WIDTH  initial state, only looked at while reset=1
//   shift_seed  out  WIDTH  current LFSR state, straight from the register
//
// Build option
//   LFSR_ZERO_GUARD_EN  when defined, the all-zero lock-up state can never be
//                       entered or held: a zero seed loads 1, and a zero state
//                       while running steps to 1. When undefined no guard
//                       logic exists and a zero seed parks the LFSR at 0 until
//                       the next reset with a non-zero seed.
// -----------------------------------------------------------------------------
module lfsr_8bit #(
    parameter int          WIDTH = 8,
    parameter logic [15:0] TAPS  = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] shift_seed
);

    // Primitive-polynomial tap masks, one per supported width.
    function automatic logic [15:0] table_mask(input int w);
        logic [15:0] m;
        case (w)
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0E08;
            13:      m = 16'h1C80;
            14:      m = 16'h3802;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    localparam logic [15:0]      MASK_SEL = (TAPS != 16'h0000) ? TAPS : table_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(MASK_SEL);

    generate
        if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
            $error("lfsr_8bit: WIDTH must be in 3..16");
        end
    endgenerate

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] load_val;
    logic             fb;

    // Feedback is the parity of the tapped bits; the new bit enters at bit 0.
    assign fb = ^(state_q & TAP_MASK);

`ifdef LFSR_ZERO_GUARD_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_comb begin
        load_val = seed;
        if (seed == '0) begin
            load_val = ONE;
        end
    end

    // A zero state can only arise from an upset; recover to 1 rather than
    // stalling forever.
    always_comb begin
        state_d = {state_q[WIDTH-2:0], fb};
        if (state_q == '0) begin
            state_d = ONE;
        end
    end
`else
    always_comb begin
        load_val = seed;
    end

    always_comb begin
        state_d = {state_q[WIDTH-2:0], fb};
    end
`endif

    // Reset takes priority over shifting on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= load_val;
        end else begin
            state_q <= state_d;
        end
    end

    assign shift_seed = state_q;

endmodule

// File: tb/tb_lfsr_8bit.sv
module tb_lfsr_8bit;

    logic       clk;
    logic       reset;
    logic [7:0] seed;
    logic [7:0] shift_seed;

    int tests_run;
    int tests_failed;

    // Reference: the output bit stream s[] of an 8-bit Fibonacci LFSR with
    // polynomial x^8+x^6+x^5+x^4+1 obeys s[n+8] = s[n]^s[n+2]^s[n+3]^s[n+4].
    // The visible state is the most recent 8 stream bits, oldest at the MSB.
    bit hist[$];

    lfsr_8bit #(.WIDTH(8), .TAPS(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed       (seed),
        .shift_seed (shift_seed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_state();
        logic [7:0] v;
        int sz;
        sz = hist.size();
        v = '0;
        for (int i = 0; i < 8; i++) v[7-i] = hist[sz-8+i];
        return v;
    endfunction

    task automatic model_load(input logic [7:0] v);
        hist.delete();
        for (int i = 7; i >= 0; i--) hist.push_back(v[i]);
    endtask

    task automatic model_edge(input logic rst, input logic [7:0] sd);
        int sz;
        bit nb;
        if (rst) begin
`ifdef LFSR_ZERO_GUARD_EN
            model_load((sd == 8'h00) ? 8'h01 : sd);
`else
            model_load(sd);
`endif
        end else begin
`ifdef LFSR_ZERO_GUARD_EN
            if (model_state() == 8'h00) begin
                model_load(8'h01);
                return;
            end
`endif
            sz = hist.size();
            nb = hist[sz-8] ^ hist[sz-6] ^ hist[sz-5] ^ hist[sz-4];
            hist.push_back(nb);
            while (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock with the current inputs, update the model, then
    // sample the DUT 1 time unit after the edge.
    task automatic step();
        logic       r;
        logic [7:0] s;
        r = reset;
        s = seed;
        @(posedge clk);
        model_edge(r, s);
        #1;
    endtask

    initial begin
        logic [7:0] exp1 [6];
        int  first_ret;
        int  distinct;
        bit  seen [256];
        logic [7:0] snap;

        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        seed  = 8'h00;
        model_load(8'h00);
        #2;

        // 1. Seed 01 sequence
        exp1[0] = 8'h01; exp1[1] = 8'h02; exp1[2] = 8'h04;
        exp1[3] = 8'h08; exp1[4] = 8'h11; exp1[5] = 8'h23;
        reset = 1'b1; seed = 8'h01;
        step();
        chk("reset_seed01", shift_seed, exp1[0]);
        reset = 1'b0;
        for (int i = 1; i < 6; i++) begin
            step();
            chk($sformatf("seq01_%0d", i), shift_seed, exp1[i]);
            chk($sformatf("seq01_model_%0d", i), shift_seed, model_state());
        end

        // 2. Period from A5
        reset = 1'b1; seed = 8'hA5;
        step();
        chk("reset_seedA5", shift_seed, 8'hA5);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[8'hA5] = 1'b1;
        distinct  = 1;
        first_ret = -1;
        for (int i = 1; i <= 255; i++) begin
            step();
            chk("period_model", shift_seed, model_state());
            if (shift_seed === 8'hA5 && first_ret < 0) first_ret = i;
            if (i < 255 && !$isunknown(shift_seed) && !seen[shift_seed]) begin
                seen[shift_seed] = 1'b1;
                distinct++;
            end
        end
        chk_int("period_first_return", first_ret, 255);
        chk_int("period_distinct", distinct, 255);
        chk("period_no_zero", {7'd0, seen[0]}, 8'h00);

        // 3. Mid-run reset to 3C
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1; seed = 8'h3C;
        step();
        chk("midrun_reset_3C", shift_seed, 8'h3C);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("after_3C", shift_seed, model_state());
        end

        // 4. Seed changes while running have no effect
        for (int i = 0; i < 20; i++) begin
            seed = 8'($urandom);
            step();
            chk("seed_ignored", shift_seed, model_state());
        end

        // 5. Zero seed
        reset = 1'b1; seed = 8'h00;
        step();
        reset = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
        chk("zero_guard_load", shift_seed, 8'h01);
        step(); chk("zero_guard_1", shift_seed, 8'h02);
        step(); chk("zero_guard_2", shift_seed, 8'h04);
`else
        chk("zero_load", shift_seed, 8'h00);
        for (int i = 0; i < 10; i++) begin
            seed = 8'($urandom);
            step();
            chk("zero_stuck", shift_seed, 8'h00);
        end
`endif

        // 6. Held reset with toggling seed
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            seed = (i % 2 == 0) ? 8'h5A : 8'hC3;
            snap = seed;
            step();
            chk("held_reset", shift_seed, snap);
            chk("held_reset_model", shift_seed, model_state());
        end
        reset = 1'b0;

        // Randomized mix of running, seed noise and occasional resets
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 19) == 0);
            seed  = 8'($urandom_range(1, 255));
            step();
            chk("random_mix", shift_seed, model_state());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
